// File: rtl/rgb_pwm_capture_pkg.sv
// Shared types and default constants for the RGB PWM duty-capture block.
package rgb_pwm_capture_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } cap_state_e;

  localparam int unsigned R_DEFAULT           = 8;
  localparam int unsigned TIMER_BITS_DEFAULT  = 8;
  localparam int unsigned FINAL_VALUE_DEFAULT = 195;

endpackage

// File: rtl/pwm_capture_ch.sv
// One PWM capture channel: synchronizer, tick-sampled edge detector, and
// high-time measurement FSM with timeout reporting for a stuck input.
module pwm_capture_ch
  import rgb_pwm_capture_pkg::*;
#(
  parameter int unsigned R = R_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       pwm_in,
  output logic [R:0] duty,
  output logic       valid
);

  localparam int unsigned   CW          = R + 2;
  localparam logic [CW-1:0] FULL_CNT    = CW'(1) << R;
  localparam logic [CW-1:0] TIMEOUT_CNT = FULL_CNT + CW'(2);

  logic [1:0]    sync_q, sync_d;
  logic          s_prev_q, s_prev_d;
  cap_state_e    state_q, state_d;
  logic [CW-1:0] period_q, period_d;
  logic [CW-1:0] high_q, high_d;
  logic [R:0]    duty_q, duty_d;
  logic          valid_q, valid_d;
  logic          s_now, rise;
  logic [CW-1:0] period_inc, high_inc;

  // s_now is the synchronized level as seen by the tick that samples it.
  assign s_now = sync_q[1];
  assign rise  = s_now & ~s_prev_q;

  always_comb begin
    sync_d     = {sync_q[0], pwm_in};
    s_prev_d   = s_prev_q;
    state_d    = state_q;
    period_d   = period_q;
    high_d     = high_q;
    duty_d     = duty_q;
    valid_d    = 1'b0;
    period_inc = period_q + CW'(1);
    high_inc   = (state_q == MEASURE && s_now && high_q < FULL_CNT) ? high_q + CW'(1) : high_q;
    if (tick) begin
      s_prev_d = s_now;
      // A rising edge outranks a timeout landing on the same tick.
      if (rise) begin
        if (state_q == MEASURE) begin
          duty_d  = high_q[R:0];
          valid_d = 1'b1;
        end
        state_d  = MEASURE;
        period_d = CW'(1);
        high_d   = CW'(1);
      end else if (period_inc == TIMEOUT_CNT) begin
        duty_d   = s_now ? FULL_CNT[R:0] : '0;
        valid_d  = 1'b1;
        period_d = '0;
        high_d   = '0;
        state_d  = IDLE;
      end else begin
        period_d = period_inc;
        high_d   = high_inc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q   <= '0;
      s_prev_q <= 1'b0;
      state_q  <= IDLE;
      period_q <= '0;
      high_q   <= '0;
      duty_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      s_prev_q <= s_prev_d;
      state_q  <= state_d;
      period_q <= period_d;
      high_q   <= high_d;
      duty_q   <= duty_d;
      valid_q  <= valid_d;
    end
  end

  assign duty  = duty_q;
  assign valid = valid_q;

endmodule

// File: rtl/rgb_pwm_capture.sv
// Three-channel PWM duty capture sharing one tick prescaler.
module rgb_pwm_capture
  import rgb_pwm_capture_pkg::*;
#(
  parameter int unsigned R          = R_DEFAULT,
  parameter int unsigned TIMER_BITS = TIMER_BITS_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [TIMER_BITS-1:0] final_value,
  input  logic                  red_pwm,
  input  logic                  green_pwm,
  input  logic                  blue_pwm,
  output logic [R:0]            red_duty,
  output logic [R:0]            green_duty,
  output logic [R:0]            blue_duty,
  output logic                  red_valid,
  output logic                  green_valid,
  output logic                  blue_valid
);

  logic [TIMER_BITS-1:0] presc_q, presc_d;
  logic                  tick;

  // Equality compare: a lowered final_value just wraps through the full range once.
  assign tick = (presc_q == final_value);

  always_comb begin
    presc_d = tick ? '0 : presc_q + TIMER_BITS'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) presc_q <= '0;
    else       presc_q <= presc_d;
  end

  pwm_capture_ch #(.R(R)) u_red (
    .clk    (clk),
    .reset  (reset),
    .tick   (tick),
    .pwm_in (red_pwm),
    .duty   (red_duty),
    .valid  (red_valid)
  );

  pwm_capture_ch #(.R(R)) u_green (
    .clk    (clk),
    .reset  (reset),
    .tick   (tick),
    .pwm_in (green_pwm),
    .duty   (green_duty),
    .valid  (green_valid)
  );

  pwm_capture_ch #(.R(R)) u_blue (
    .clk    (clk),
    .reset  (reset),
    .tick   (tick),
    .pwm_in (blue_pwm),
    .duty   (blue_duty),
    .valid  (blue_valid)
  );

endmodule

// File: tb/tb_rgb_pwm_capture.sv
// Directed bench for rgb_pwm_capture: PWM pattern generators feed the DUT,
// expected duties are queued per channel and popped on each valid strobe.
module tb_rgb_pwm_capture;

  localparam int unsigned R = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [7:0]   final_value = '0;
  logic [2:0]   pwm_v = '0;
  logic [R:0]   red_duty, green_duty, blue_duty;
  logic         red_valid, green_valid, blue_valid;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic rst_seen = 1'b1;

  int per[3] = '{1, 1, 1};
  int hi[3]  = '{0, 0, 0};
  int gcnt[3] = '{0, 0, 0};
  bit en[3] = '{0, 0, 0};
  int exp_int[3] = '{0, 0, 0};
  int last_t[3] = '{-1, -1, -1};
  string names[3] = '{"red", "green", "blue"};

  int q_r[$];
  int q_g[$];
  int q_b[$];

  rgb_pwm_capture #(.R(8), .TIMER_BITS(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .final_value (final_value),
    .red_pwm     (pwm_v[0]),
    .green_pwm   (pwm_v[1]),
    .blue_pwm    (pwm_v[2]),
    .red_duty    (red_duty),
    .green_duty  (green_duty),
    .blue_duty   (blue_duty),
    .red_valid   (red_valid),
    .green_valid (green_valid),
    .blue_valid  (blue_valid)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_seen <= reset;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic mon(input int c, input logic v, input logic [R:0] d);
    int e;
    bit have;
    e = 0;
    have = 1'b0;
    if (v !== 1'b1) return;
    checks++;
    assert (rst_seen === 1'b0) else begin
      errors++;
      $error("FAIL %s_valid_in_reset: observed valid=1 expected valid=0", names[c]);
    end
    if (!en[c]) return;
    case (c)
      0: begin have = (q_r.size() > 0); if (have) e = q_r.pop_front(); end
      1: begin have = (q_g.size() > 0); if (have) e = q_g.pop_front(); end
      default: begin have = (q_b.size() > 0); if (have) e = q_b.pop_front(); end
    endcase
    checks++;
    assert (have) else begin
      errors++;
      $error("FAIL %s_unexpected_valid: observed duty=%0d expected no publish", names[c], d);
    end
    if (!have) return;
    chk($sformatf("%s_duty", names[c]), int'(d), e);
    if (exp_int[c] != 0 && last_t[c] >= 0)
      chk($sformatf("%s_interval", names[c]), cyc - last_t[c], exp_int[c]);
    last_t[c] = cyc;
  endtask

  always @(negedge clk) begin
    if (rst_seen) last_t = '{-1, -1, -1};
    mon(0, red_valid, red_duty);
    mon(1, green_valid, green_duty);
    mon(2, blue_valid, blue_duty);
  end

  task automatic step();
    @(posedge clk);
    #1;
    for (int c = 0; c < 3; c++) begin
      pwm_v[c] = (gcnt[c] < hi[c]);
      gcnt[c]  = (gcnt[c] + 1) % per[c];
    end
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic gen_load(input int c, input int p, input int h);
    per[c]   = p;
    hi[c]    = h;
    pwm_v[c] = (h > 0);
    gcnt[c]  = 1 % p;
  endtask

  task automatic do_reset();
    en = '{0, 0, 0};
    reset = 1'b1;
    repeat (4) step();
    q_r.delete();
    q_g.delete();
    q_b.delete();
  endtask

  task automatic reset_state_chk(input string tag);
    chk({tag, "_red_duty"}, int'(red_duty), 0);
    chk({tag, "_green_duty"}, int'(green_duty), 0);
    chk({tag, "_blue_duty"}, int'(blue_duty), 0);
    chk({tag, "_red_valid"}, int'(red_valid), 0);
    chk({tag, "_green_valid"}, int'(green_valid), 0);
    chk({tag, "_blue_valid"}, int'(blue_valid), 0);
  endtask

  task automatic drain(input string tag);
    repeat (6) step();
    chk({tag, "_red_pending"}, q_r.size(), 0);
    chk({tag, "_green_pending"}, q_g.size(), 0);
    chk({tag, "_blue_pending"}, q_b.size(), 0);
  endtask

  initial begin
    int n;
    bit seen;
    logic any_v;

    // Reset state
    do_reset();
    reset_state_chk("por");

    // Red 64/256, green stuck low, blue stuck high; tick every clock
    final_value = 8'd0;
    gen_load(0, 256, 64);
    gen_load(1, 1, 0);
    gen_load(2, 1, 1);
    repeat (4) begin q_r.push_back(64); q_g.push_back(0); q_b.push_back(256); end
    exp_int = '{256, 258, 258};
    en = '{1, 1, 1};
    reset = 1'b0;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 400) begin
      step();
      n++;
      if (green_valid === 1'b1) seen = 1'b1;
    end
    chk("green_first_timeout_clocks", n, 258);
    run(1100 - n);
    drain("phase_a");

    // 128/256 input with a reset pulse in the low phase
    do_reset();
    reset_state_chk("phase_b_start");
    gen_load(0, 256, 128);
    gen_load(1, 1, 0);
    gen_load(2, 1, 0);
    q_r.push_back(128);
    exp_int = '{256, 0, 0};
    en = '{1, 0, 0};
    reset = 1'b0;
    run(400);
    chk("phase_b_pre_reset_red_duty", int'(red_duty), 128);
    reset = 1'b1;
    any_v = 1'b0;
    repeat (8) begin
      step();
      any_v = any_v | red_valid | green_valid | blue_valid;
    end
    chk("mid_reset_any_valid", int'(any_v), 0);
    reset_state_chk("mid_reset");
    reset = 1'b0;
    q_r.push_back(128);
    run(450);
    drain("phase_b");

    // final_value=3: blue 32 ticks high of 256
    do_reset();
    final_value = 8'd3;
    gen_load(0, 1, 0);
    gen_load(1, 1, 0);
    gen_load(2, 1024, 128);
    repeat (2) q_b.push_back(32);
    exp_int = '{0, 0, 1024};
    en = '{0, 0, 1};
    reset = 1'b0;
    run(2200);
    drain("phase_c");

    // Edge lands on the timeout tick: green 100 high, red 256 high of 257
    do_reset();
    final_value = 8'd0;
    gen_load(0, 257, 256);
    gen_load(1, 257, 100);
    gen_load(2, 1, 0);
    repeat (4) begin q_r.push_back(256); q_g.push_back(100); end
    exp_int = '{257, 257, 0};
    en = '{1, 1, 0};
    reset = 1'b0;
    run(1100);
    drain("phase_d");

    // Driver-like duties 0/100/256 with final_value=1, all channels live
    do_reset();
    final_value = 8'd1;
    gen_load(0, 1, 0);
    gen_load(1, 512, 200);
    gen_load(2, 1, 1);
    repeat (2) begin q_r.push_back(0); q_g.push_back(100); q_b.push_back(256); end
    exp_int = '{516, 512, 516};
    en = '{1, 1, 1};
    reset = 1'b0;
    run(1300);
    drain("phase_e");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
